// File: rtl/ysyx_23060191_ifu.sv
// ysyx_23060191_ifu -- instruction fetch unit.
//
// Holds the architectural PC and fetches one instruction at a time. Each
// fetch runs through four states:
//   REQ    - issue a read on the request channel
//   WAIT   - wait for the response, or give up after TIMEOUT_CYC cycles
//   HOLD   - present the word to the decoder
//   PCWAIT - wait for the next PC from the PC-update unit
// A fetch that fails (bus error, timeout or misaligned next PC) presents
// NOP_INST with o_fetch_err set.
//
// Optional macro IFU_PERF_CNT_EN enables the o_fetch_cnt and o_stall_cnt
// performance counters. When it is undefined, both ports are tied to zero.
//
// Ports:
//   i_clk, i_rst                    clock (rising edge); synchronous active-high reset
//   o_req_valid/o_req_addr/i_req_ready   memory read request (address = PC)
//   i_rsp_valid/i_rsp_data/i_rsp_err     memory read response
//   o_inst/o_inst_pc/o_inst_valid/i_inst_ready  instruction to decode
//   o_fetch_err                     qualifies o_inst_valid; the fetch failed
//   i_pc_wen/i_next_pc              next PC from the PC-update unit
//   o_fetch_cnt/o_stall_cnt         completed fetches / cycles spent in WAIT
module ysyx_23060191_ifu #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_req_valid,
  output logic [31:0] o_req_addr,
  input  logic        i_req_ready,
  input  logic        i_rsp_valid,
  input  logic [31:0] i_rsp_data,
  input  logic        i_rsp_err,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic        o_fetch_err,
  input  logic        i_pc_wen,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_fetch_cnt,
  output logic [31:0] o_stall_cnt
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, PCWAIT} state_t;

  // The timeout fires in the WAIT cycle whose counter value is TIMEOUT_CYC-1,
  // which makes that cycle the TIMEOUT_CYC-th one spent in WAIT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst, inst_nxt;
  logic [31:0] inst_pc, inst_pc_nxt;
  logic        err, err_nxt;
  logic [7:0]  tcnt, tcnt_nxt;
  logic        take_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= '0;
      err     <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      inst    <= inst_nxt;
      inst_pc <= inst_pc_nxt;
      err     <= err_nxt;
      tcnt    <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    inst_nxt    = inst;
    inst_pc_nxt = inst_pc;
    err_nxt     = err;
    tcnt_nxt    = tcnt;
    take_pc     = 1'b0;

    case (state)
      REQ: begin
        if (i_req_ready) begin
          state_nxt = WAIT;
          tcnt_nxt  = '0;
        end
      end
      WAIT: begin
        tcnt_nxt = tcnt + 8'd1;
        // A response in the same cycle as the timeout takes priority.
        if (i_rsp_valid) begin
          inst_nxt    = i_rsp_err ? NOP_INST : i_rsp_data;
          inst_pc_nxt = pc;
          err_nxt     = i_rsp_err;
          state_nxt   = HOLD;
        end else if (tcnt == TO_LAST) begin
          inst_nxt    = NOP_INST;
          inst_pc_nxt = pc;
          err_nxt     = 1'b1;
          state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (i_inst_ready) begin
          state_nxt = PCWAIT;
          take_pc   = i_pc_wen;
        end
      end
      PCWAIT: begin
        take_pc = i_pc_wen;
      end
      default: state_nxt = REQ;
    endcase

    // Shared next-PC path: reached from PCWAIT, or directly from HOLD when the
    // decode handshake and the next PC arrive in the same cycle.
    if (take_pc) begin
      pc_nxt = i_next_pc;
      if (i_next_pc[1:0] != 2'b00) begin
        inst_nxt    = NOP_INST;
        inst_pc_nxt = i_next_pc;
        err_nxt     = 1'b1;
        state_nxt   = HOLD;
      end else begin
        state_nxt = REQ;
      end
    end
  end

  // Valid outputs are decoded from state and masked by reset so that they
  // read 0 while i_rst is held.
  assign o_req_valid  = (state == REQ) && !i_rst;
  assign o_inst_valid = (state == HOLD) && !i_rst;
  assign o_req_addr   = pc;
  assign o_inst       = inst;
  assign o_inst_pc    = inst_pc;
  assign o_fetch_err  = err;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == HOLD && i_inst_ready && fetch_cnt != '1)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (state == WAIT && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = fetch_cnt;
  assign o_stall_cnt = stall_cnt;
`else
  assign o_fetch_cnt = '0;
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_23060191_ifu.sv
// Self-checking bench for ysyx_23060191_ifu. Stimulus pushes the expected
// request addresses and instruction beats into queues; a monitor on the
// falling edge pops and compares them at every handshake.
module tb_ysyx_23060191_ifu;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } beat_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        o_req_valid;
  logic [31:0] o_req_addr;
  logic        i_req_ready = 1'b0;
  logic        i_rsp_valid = 1'b0;
  logic [31:0] i_rsp_data = '0;
  logic        i_rsp_err = 1'b0;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready = 1'b0;
  logic        o_fetch_err;
  logic        i_pc_wen = 1'b0;
  logic [31:0] i_next_pc = '0;
  logic [31:0] o_fetch_cnt;
  logic [31:0] o_stall_cnt;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [31:0] req_q[$];
  beat_t       inst_q[$];

  ysyx_23060191_ifu #(
    .RESET_PC   (32'h8000_0000),
    .TIMEOUT_CYC(255),
    .NOP_INST   (32'h0000_0013)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_req_valid (o_req_valid),
    .o_req_addr  (o_req_addr),
    .i_req_ready (i_req_ready),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_data  (i_rsp_data),
    .i_rsp_err   (i_rsp_err),
    .o_inst      (o_inst),
    .o_inst_pc   (o_inst_pc),
    .o_inst_valid(o_inst_valid),
    .i_inst_ready(i_inst_ready),
    .o_fetch_err (o_fetch_err),
    .i_pc_wen    (i_pc_wen),
    .i_next_pc   (i_next_pc),
    .o_fetch_cnt (o_fetch_cnt),
    .o_stall_cnt (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: compares every request and decode handshake against the queues.
  initial begin
    beat_t b;
    forever begin
      @(negedge i_clk);
      if (!i_rst && o_req_valid && i_req_ready) begin
        if (req_q.size() == 0) check("req_unexpected", o_req_addr, 32'hFFFF_FFFF);
        else check("req_addr", o_req_addr, req_q.pop_front());
      end
      if (!i_rst && o_inst_valid && i_inst_ready) begin
        if (inst_q.size() == 0) check("inst_unexpected", o_inst, 32'hFFFF_FFFF);
        else begin
          b = inst_q.pop_front();
          check("inst", o_inst, b.inst);
          check("inst_pc", o_inst_pc, b.pc);
          check("fetch_err", {31'd0, o_fetch_err}, {31'd0, b.err});
        end
      end
    end
  end

  // Full fetch from REQ: accept, respond after nwait WAIT cycles, then
  // handshake with the next PC in the same cycle.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                       input int nwait, input logic [31:0] nxt);
    beat_t b;
    b.inst = err ? NOP : data;
    b.pc   = addr;
    b.err  = err;
    req_q.push_back(addr);
    inst_q.push_back(b);
    i_req_ready = 1'b1;
    step();
    i_req_ready = 1'b0;
    repeat (nwait - 1) step();
    i_rsp_valid = 1'b1; i_rsp_data = data; i_rsp_err = err;
    step();
    i_rsp_valid = 1'b0; i_rsp_err = 1'b0;
    check("hold_valid", {31'd0, o_inst_valid}, 32'd1);
    i_inst_ready = 1'b1; i_pc_wen = 1'b1; i_next_pc = nxt;
    step();
    i_inst_ready = 1'b0; i_pc_wen = 1'b0;
  endtask

  initial begin
    beat_t b;
    int waited;

    // Reset state
    i_rst = 1'b1;
    step(); step();
    check("rst_req_valid", {31'd0, o_req_valid}, 32'd0);
    check("rst_inst_valid", {31'd0, o_inst_valid}, 32'd0);
    check("rst_fetch_err", {31'd0, o_fetch_err}, 32'd0);
    check("rst_inst", o_inst, 32'd0);
    check("rst_addr", o_req_addr, 32'h8000_0000);
    check("rst_fetch_cnt", o_fetch_cnt, 32'd0);
    check("rst_stall_cnt", o_stall_cnt, 32'd0);

    // First fetch, response one cycle after acceptance, 5-cycle decode stall
    req_q.push_back(32'h8000_0000);
    b.inst = 32'h0000_0297; b.pc = 32'h8000_0000; b.err = 1'b0;
    inst_q.push_back(b);
    i_rst = 1'b0;
    i_req_ready = 1'b1;
    #1;
    check("first_req_valid", {31'd0, o_req_valid}, 32'd1);
    step();
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b1; i_rsp_data = 32'h0000_0297;
    step();
    i_rsp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("hold_inst", o_inst, 32'h0000_0297);
      check("hold_pc", o_inst_pc, 32'h8000_0000);
      check("hold_valid5", {31'd0, o_inst_valid}, 32'd1);
      step();
    end
    req_q.push_back(32'h8000_0004);
    i_inst_ready = 1'b1; i_pc_wen = 1'b1; i_next_pc = 32'h8000_0004;
    step();
    i_inst_ready = 1'b0; i_pc_wen = 1'b0;
    check("next_req_valid", {31'd0, o_req_valid}, 32'd1);
    check("next_req_addr", o_req_addr, 32'h8000_0004);

    // Request back-pressure for 3 cycles
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_req_valid", {31'd0, o_req_valid}, 32'd1);
      check("bp_req_addr", o_req_addr, 32'h8000_0004);
    end

    // Bus error response after 3 WAIT cycles; handshake without next PC
    b.inst = NOP; b.pc = 32'h8000_0004; b.err = 1'b1;
    inst_q.push_back(b);
    i_req_ready = 1'b1;
    step();
    i_req_ready = 1'b0;
    step(); step();
    i_rsp_valid = 1'b1; i_rsp_err = 1'b1; i_rsp_data = 32'hDEAD_BEEF;
    step();
    i_rsp_valid = 1'b0; i_rsp_err = 1'b0;
    i_inst_ready = 1'b1;
    step();
    i_inst_ready = 1'b0;
    check("pcwait_inst_valid", {31'd0, o_inst_valid}, 32'd0);
    check("pcwait_req_valid", {31'd0, o_req_valid}, 32'd0);
    step(); step();
    req_q.push_back(32'h8000_0008);
    i_pc_wen = 1'b1; i_next_pc = 32'h8000_0008;
    step();
    i_pc_wen = 1'b0;

    // Timeout: no response for 255 WAIT cycles
    b.inst = NOP; b.pc = 32'h8000_0008; b.err = 1'b1;
    inst_q.push_back(b);
    i_req_ready = 1'b1;
    step();
    i_req_ready = 1'b0;
    waited = 0;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (o_inst_valid) begin
        waited = k;
        break;
      end
    end
    check("timeout_cycles", waited, 32'd255);

    // Misaligned next PC taken on the handshake cycle: no request, error beat
    b.inst = NOP; b.pc = 32'h8000_0002; b.err = 1'b1;
    inst_q.push_back(b);
    i_inst_ready = 1'b1; i_pc_wen = 1'b1; i_next_pc = 32'h8000_0002;
    step();
    i_inst_ready = 1'b0; i_pc_wen = 1'b0;
    check("misalign_req_valid", {31'd0, o_req_valid}, 32'd0);
    check("misalign_inst_valid", {31'd0, o_inst_valid}, 32'd1);
    check("misalign_pc", o_inst_pc, 32'h8000_0002);
    req_q.push_back(32'h8000_0010);
    i_inst_ready = 1'b1; i_pc_wen = 1'b1; i_next_pc = 32'h8000_0010;
    step();
    i_inst_ready = 1'b0; i_pc_wen = 1'b0;

    // Reset during WAIT, then a late response
    i_req_ready = 1'b1;
    step();
    i_req_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
    check("pre_rst_fetch_cnt", o_fetch_cnt, 32'd4);
    check("pre_rst_stall_cnt", o_stall_cnt, 32'd259);
`else
    check("pre_rst_fetch_cnt", o_fetch_cnt, 32'd0);
    check("pre_rst_stall_cnt", o_stall_cnt, 32'd0);
`endif
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    i_rsp_valid = 1'b1; i_rsp_data = 32'hDEAD_BEEF;
    step();
    i_rsp_valid = 1'b0;
    check("late_rsp_req_valid", {31'd0, o_req_valid}, 32'd1);
    check("late_rsp_addr", o_req_addr, 32'h8000_0000);
    check("late_rsp_inst_valid", {31'd0, o_inst_valid}, 32'd0);
    check("late_rsp_inst", o_inst, 32'd0);

    // Two fetches with 3 WAIT cycles each
    fetch(32'h8000_0000, 32'h0010_0093, 1'b0, 3, 32'h8000_0004);
    fetch(32'h8000_0004, 32'h0020_0113, 1'b0, 3, 32'h8000_0008);
`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", o_fetch_cnt, 32'd2);
    check("stall_cnt", o_stall_cnt, 32'd6);
`else
    check("fetch_cnt", o_fetch_cnt, 32'd0);
    check("stall_cnt", o_stall_cnt, 32'd0);
`endif

    step();
    check("req_q_empty", req_q.size(), 32'd0);
    check("inst_q_empty", inst_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
